mem_port_arbiter: RTL and testbench

- Sequences a single-port unified memory shared by the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Arbitrates between the two ports, issues one memory command at a time, and counts the fixed memory latency.
- Returns read data with a one-cycle ack pulse and produces stall_if / stall_mem for the hazard logic.
- Sits between the pipeline's fetch/data ports and the shared memory array.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and the shared single-port memory command bus
// that mem_port_arbiter sequences between them.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stage accesses onto one fixed-latency memory port,
// one command at a time, with a starvation guard for instruction fetch.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LAT          = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [3:0]          LAT_CNT    = 4'(LAT);

    logic [1:0]          state;
    logic                grantData;
    logic [3:0]          latCnt;
    logic [STREAK_W-1:0] dataStreak;
    logic                memEn, memWe, ifAck, dAck, busyReg;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memWdata, ifRdata, dRdata;
    logic                anyReq, ifWins;

    // Data has priority unless it has already won STARVE_LIMIT times in a row over a waiting fetch.
    always_comb begin
        anyReq = bus.if_req | bus.d_req;
        ifWins = bus.if_req & (~bus.d_req | (dataStreak == STREAK_MAX));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grantData  <= 1'b0;
            latCnt     <= '0;
            dataStreak <= '0;
            memEn      <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            ifAck      <= 1'b0;
            dAck       <= 1'b0;
            ifRdata    <= '0;
            dRdata     <= '0;
            busyReg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grantData <= ~ifWins;
                        memEn     <= 1'b1;
                        busyReg   <= 1'b1;
                        state     <= ISSUE;
                        if (ifWins) begin
                            memAddr    <= bus.if_addr;
                            memWe      <= 1'b0;
                            memWdata   <= '0;
                            dataStreak <= '0;
                        end else begin
                            memAddr    <= bus.d_addr;
                            memWe      <= bus.d_we;
                            memWdata   <= bus.d_wdata;
                            dataStreak <= bus.if_req ? dataStreak + STREAK_W'(1) : '0;
                        end
                    end
                end
                ISSUE: begin
                    memEn  <= 1'b0;
                    latCnt <= LAT_CNT;
                    state  <= WAIT;
                end
                WAIT: begin
                    // latCnt==1 marks the cycle in which mem_rdata is valid.
                    if (latCnt == 4'd1) begin
                        if (grantData) begin
                            dRdata <= bus.mem_rdata;
                            dAck   <= 1'b1;
                        end else begin
                            ifRdata <= bus.mem_rdata;
                            ifAck   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        latCnt <= latCnt - 4'd1;
                    end
                end
                default: begin
                    ifAck   <= 1'b0;
                    dAck    <= 1'b0;
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.if_ack    = ifAck;
    assign bus.if_rdata  = ifRdata;
    assign bus.d_ack     = dAck;
    assign bus.d_rdata   = dRdata;
    assign bus.busy      = busyReg;
    assign bus.stall_if  = bus.if_req & ~ifAck;
    assign bus.stall_mem = bus.d_req & ~dAck;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LAT=2/STARVE_LIMIT=2 main instance with a
// scoreboarded memory model, plus LAT=1 and LAT=15 instances for latency.
module tb_mem_port_arbiter;
    localparam int MAIN_LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lat1Bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lat15Bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(MAIN_LAT), .STARVE_LIMIT(2)) dut (
        .clock(clock), .reset(reset), .bus(bus));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .STARVE_LIMIT(4)) dutLat1 (
        .clock(clock), .reset(reset), .bus(lat1Bus));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(15), .STARVE_LIMIT(4)) dutLat15 (
        .clock(clock), .reset(reset), .bus(lat15Bus));

    typedef struct {
        bit          isD;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        issueQ[$];
    txn_t        ackQ[$];
    txn_t        cur;
    int          issueCyc = -100;
    logic [31:0] lastIf = '0;
    logic [31:0] lastD  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic failEvent(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s, want none", name, what);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Memory model + scoreboard: commands checked at mem_en, data presented only LAT cycles later.
    always @(negedge clock) begin
        txn_t t;
        if (!reset) begin
            issueQ.delete();
            ackQ.delete();
            issueCyc = -100;
            lastIf   = '0;
            lastD    = '0;
        end else begin
            if (cyc == issueCyc + 1) check("mem_en single cycle", bus.mem_en, 1'b0);
            if (bus.mem_en) begin
                if (issueQ.size() == 0) failEvent("unexpected mem_en", "a command");
                else begin
                    cur = issueQ.pop_front();
                    check("mem_addr", bus.mem_addr, cur.addr);
                    check("mem_we", bus.mem_we, cur.we);
                    if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
                    issueCyc = cyc;
                    ackQ.push_back(cur);
                end
            end
            if (bus.if_ack && bus.d_ack) failEvent("ack overlap", "both acks");
            else if (bus.if_ack || bus.d_ack) begin
                if (ackQ.size() == 0) failEvent("unexpected ack", "an ack");
                else begin
                    t = ackQ.pop_front();
                    check("ack port is data", bus.d_ack, t.isD);
                    check("busy during ack", bus.busy, 1'b1);
                    if (t.isD) begin
                        lastD = t.rdata;
                        if (!t.we) check("d_rdata", bus.d_rdata, t.rdata);
                        check("if_rdata held", bus.if_rdata, lastIf);
                    end else begin
                        lastIf = t.rdata;
                        check("if_rdata", bus.if_rdata, t.rdata);
                        check("d_rdata held", bus.d_rdata, lastD);
                    end
                end
            end
        end
        bus.mem_rdata = (cyc == issueCyc + MAIN_LAT) ? cur.rdata : 32'hBAD0_BAD0;
    end

    int auxIss1  = -100;
    int auxIss15 = -100;
    always @(negedge clock) begin
        if (lat1Bus.mem_en) auxIss1 = cyc;
        if (lat15Bus.mem_en) auxIss15 = cyc;
        lat1Bus.mem_rdata  = (cyc == auxIss1 + 1)   ? 32'h0000_1111 : 32'hBAD0_BAD0;
        lat15Bus.mem_rdata = (cyc == auxIss15 + 15) ? 32'h0000_FFFF : 32'hBAD0_BAD0;
    end

    task automatic runTxn(input txn_t t);
        int   n;
        int   startCyc;
        bit   done;
        logic stall;
        issueQ.push_back(t);
        if (t.isD) begin
            bus.d_req = 1'b1; bus.d_we = t.we; bus.d_addr = t.addr; bus.d_wdata = t.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = t.addr;
        end
        startCyc = cyc;
        #1;
        check("stall at request", t.isD ? bus.stall_mem : bus.stall_if, 1'b1);
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            tick();
            n++;
            done  = t.isD ? bus.d_ack : bus.if_ack;
            stall = t.isD ? bus.stall_mem : bus.stall_if;
            check(done ? "stall in ack cycle" : "stall while waiting", stall, !done);
        end
        check("request-to-ack latency", n + 1, MAIN_LAT + 3);
        check("issue one cycle after request", issueCyc - startCyc, 1);
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
        tick();
        check("idle after transaction", bus.busy, 1'b0);
    endtask

    initial begin
        txn_t vecs[6];
        txn_t t;
        bit   order[6];
        int   acks, gaps, n;
        bit   seenBusy;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0BAD_F00D};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,          32'h1357_9BDF};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'hA5A5_5A5A};

        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        lat1Bus.if_req = 0; lat1Bus.if_addr = '0; lat1Bus.d_req = 0; lat1Bus.d_we = 0;
        lat1Bus.d_addr = '0; lat1Bus.d_wdata = '0;
        lat15Bus.if_req = 0; lat15Bus.if_addr = '0; lat15Bus.d_req = 0; lat15Bus.d_we = 0;
        lat15Bus.d_addr = '0; lat15Bus.d_wdata = '0;

        repeat (2) tick();
        check("reset busy", bus.busy, 1'b0);
        check("reset mem_en", bus.mem_en, 1'b0);
        check("reset mem_we", bus.mem_we, 1'b0);
        check("reset if_ack", bus.if_ack, 1'b0);
        check("reset d_ack", bus.d_ack, 1'b0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        check("reset mem_wdata", bus.mem_wdata, 32'h0);
        check("reset if_rdata", bus.if_rdata, 32'h0);
        check("reset d_rdata", bus.d_rdata, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) runTxn(vecs[i]);

        // Both requesters held: with STARVE_LIMIT=2 grants go D,D,I,D,D,I.
        order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            t = '{order[i], 1'b0, order[i] ? 32'h0000_0100 : 32'h0000_0200, 32'h0, 32'h1000_0000 + i};
            issueQ.push_back(t);
        end
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.if_req = 1; bus.if_addr = 32'h200;
        acks = 0; gaps = 0; n = 0; seenBusy = 0;
        while (acks < 6 && n < 200) begin
            tick();
            n++;
            if (bus.busy) seenBusy = 1;
            else if (seenBusy) gaps++;
            if (bus.if_ack || bus.d_ack) acks++;
        end
        bus.d_req = 0; bus.if_req = 0;
        check("starve ack count", acks, 6);
        check("starve idle gaps", gaps, 5);
        check("starve grants consumed", issueQ.size(), 0);
        tick();

        // Address changed during WAIT: first access keeps 0x40, held req then uses 0x80.
        issueQ.push_back('{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h4040_0001});
        issueQ.push_back('{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h8080_0002});
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        tick(); tick();
        bus.d_addr = 32'h80;
        acks = 0; n = 0;
        while (acks < 2 && n < 60) begin
            tick();
            n++;
            if (bus.d_ack) acks++;
        end
        bus.d_req = 0;
        check("addr-change ack count", acks, 2);
        tick();

        // Reset in mid-WAIT aborts the load with no ack.
        issueQ.push_back('{1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h7777_7777});
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("abort busy", bus.busy, 1'b0);
        check("abort mem_en", bus.mem_en, 1'b0);
        check("abort d_ack", bus.d_ack, 1'b0);
        bus.d_req = 0;
        tick();
        reset = 1'b1;
        acks = 0;
        repeat (8) begin
            tick();
            if (bus.d_ack) acks++;
        end
        check("no ack after abort", acks, 0);
        runTxn('{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h5A5A_1234});

        lat1Bus.if_req = 1; lat1Bus.if_addr = 32'h20;
        n = 0;
        while (!lat1Bus.if_ack && n < 60) begin tick(); n++; end
        lat1Bus.if_req = 0;
        check("LAT=1 latency", n + 1, 4);
        check("LAT=1 if_rdata", lat1Bus.if_rdata, 32'h0000_1111);

        lat15Bus.if_req = 1; lat15Bus.if_addr = 32'h24;
        n = 0;
        while (!lat15Bus.if_ack && n < 60) begin tick(); n++; end
        lat15Bus.if_req = 0;
        check("LAT=15 latency", n + 1, 18);
        check("LAT=15 if_rdata", lat15Bus.if_rdata, 32'h0000_FFFF);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1);
    end
endmodule
